// File: rtl/dffsr_bank_pkg.sv
// dffsr_bank_pkg
// Shared types and helpers for the dffsr_bank register bank.
//   mode_e      : word-level operation select of the mode unit
//   modeRes_t   : mode unit result (next word, shift-out bit, shift-out valid)
//   modeResult  : computes the mode unit result for a bank of width w (2..MAX_W)
package dffsr_bank_pkg;

  // Widest bank the helper function can serve; callers zero-extend into it.
  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INV  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  typedef struct packed {
    logic [MAX_W-1:0] val;
    logic             so;
    logic             soUpd;
  } modeRes_t;

  // Only bits [w-1:0] of val are meaningful. Shifts are built from masks
  // rather than variable bit selects so the width argument never needs to
  // index a vector directly.
  function automatic modeRes_t modeResult(input mode_e            mode,
                                          input logic [MAX_W-1:0] q,
                                          input logic [MAX_W-1:0] d,
                                          input logic             si,
                                          input int               w);
    modeRes_t         res;
    logic [MAX_W-1:0] one;
    logic [MAX_W-1:0] topBit;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] siExt;
    logic             msb;
    logic             lsb;
    one    = '0;
    one[0] = 1'b1;
    topBit = one << (w - 1);
    // For w == MAX_W the shift yields zero and the subtraction wraps to all ones.
    mask   = (one << w) - one;
    siExt  = si ? one : '0;
    msb    = |(q & topBit);
    lsb    = q[0];
    res.val   = q;
    res.so    = 1'b0;
    res.soUpd = 1'b0;
    unique case (mode)
      MODE_LOAD: res.val = d;
      MODE_SHL: begin
        res.val   = (q << 1) | siExt;
        res.so    = msb;
        res.soUpd = 1'b1;
      end
      MODE_SHR: begin
        res.val   = ((q & mask) >> 1) | (si ? topBit : '0);
        res.so    = lsb;
        res.soUpd = 1'b1;
      end
      MODE_ROL: begin
        res.val   = (q << 1) | (msb ? one : '0);
        res.so    = msb;
        res.soUpd = 1'b1;
      end
      MODE_ROR: begin
        res.val   = ((q & mask) >> 1) | (lsb ? topBit : '0);
        res.so    = lsb;
        res.soUpd = 1'b1;
      end
      MODE_INV: res.val = ~q;
      default:  res.val = q;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dffsr_cell.sv
// dffsr_cell
// One bit of the register bank: synchronous active-low reset, then CLR,
// then SET, then the supplied next value.
//   clk_i    : rising-edge clock
//   rst_ni   : synchronous reset, active-low
//   rstVal_i : value loaded on reset
//   set_i    : synchronous set
//   clr_i    : synchronous clear (wins over set)
//   d_i      : next value from the mode unit
//   q_d_o    : next value after set/clear masking (reset excluded)
//   q_o      : registered bit
module dffsr_cell (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rstVal_i,
  input  logic set_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_d_o,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // Clear beats set so a conflicting request always leaves the bit at 0.
  always_comb begin
    q_d = d_i;
    if (clr_i) begin
      q_d = 1'b0;
    end else if (set_i) begin
      q_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= rstVal_i;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_d_o = q_d;
  assign q_o   = q_q;

endmodule

// File: rtl/dffsr_bank.sv
// dffsr_bank
// WIDTH-bit register bank with per-bit synchronous set/clear and a word-level
// mode unit (hold, load, shift, rotate, invert). Also reports a set/clear
// conflict flag and a saturating count of cycles in which Q changed.
// Optional feature macro DFFSR_BANK_PARITY_EN adds par_o, the registered even
// parity of Q.
//   clk_i      : rising-edge clock
//   rst_ni     : synchronous reset, active-low
//   en_i       : mode enable (low = mode unit holds)
//   mode_i     : operation select (see dffsr_bank_pkg::mode_e)
//   d_i        : parallel load data
//   si_i       : serial input for shifts
//   set_i      : per-bit synchronous set
//   clr_i      : per-bit synchronous clear
//   q_o        : register contents
//   so_o       : bit shifted or rotated out by the last shift/rotate
//   conflict_o : set and clear were both high on some bit last cycle
//   par_o      : even parity of q_o (only with DFFSR_BANK_PARITY_EN)
//   chg_cnt_o  : saturating count of cycles in which Q changed
module dffsr_bank
  import dffsr_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             si_i,
  input  logic [WIDTH-1:0] set_i,
  input  logic [WIDTH-1:0] clr_i,
  output logic [WIDTH-1:0] q_o,
  output logic             so_o,
  output logic             conflict_o,
`ifdef DFFSR_BANK_PARITY_EN
  output logic             par_o,
`endif
  output logic [CNT_W-1:0] chg_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] modeVal;
  logic [MAX_W-1:0] qExt;
  logic [MAX_W-1:0] dExt;
  modeRes_t         res;

  logic             so_q,       so_d;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] chgCnt_q,   chgCnt_d;

  // Zero-extend into the helper's fixed width.
  always_comb begin
    qExt             = '0;
    dExt             = '0;
    qExt[WIDTH-1:0]  = q;
    dExt[WIDTH-1:0]  = d_i;
  end

  assign res     = modeResult(mode_e'(mode_i), qExt, dExt, si_i, WIDTH);
  assign modeVal = en_i ? res.val[WIDTH-1:0] : q;

  if (WIDTH < MAX_W) begin : g_unused
    logic unusedHighBits;
    assign unusedHighBits = ^res.val[MAX_W-1:WIDTH];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    dffsr_cell u_cell (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .rstVal_i (RESET_VAL[i]),
      .set_i    (set_i[i]),
      .clr_i    (clr_i[i]),
      .d_i      (modeVal[i]),
      .q_d_o    (q_d[i]),
      .q_o      (q[i])
    );
  end

  // q_d already includes the set/clear masks, so the counter sees exactly
  // what the cells will store.
  always_comb begin
    so_d       = so_q;
    conflict_d = |(set_i & clr_i);
    chgCnt_d   = chgCnt_q;
    if (en_i && res.soUpd) begin
      so_d = res.so;
    end
    if ((q_d != q) && (chgCnt_q != CNT_MAX)) begin
      chgCnt_d = chgCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      so_q       <= 1'b0;
      conflict_q <= 1'b0;
      chgCnt_q   <= '0;
    end else begin
      so_q       <= so_d;
      conflict_q <= conflict_d;
      chgCnt_q   <= chgCnt_d;
    end
  end

`ifdef DFFSR_BANK_PARITY_EN
  logic par_q;

  // Parity is taken from the next word so it lines up with Q on every edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      par_q <= ^RESET_VAL;
    end else begin
      par_q <= ^q_d;
    end
  end

  assign par_o = par_q;
`endif

  assign q_o        = q;
  assign so_o       = so_q;
  assign conflict_o = conflict_q;
  assign chg_cnt_o  = chgCnt_q;

endmodule

// File: tb/tb_dffsr_bank.sv
// tb_dffsr_bank
// Directed table-driven bench for dffsr_bank with WIDTH=8, RESET_VAL=8'hA5,
// CNT_W=4, plus hand-written saturation and mid-operation reset sequences.
// Builds with or without DFFSR_BANK_PARITY_EN.
module tb_dffsr_bank;

  logic       clk;
  logic       rstN;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       si;
  logic [7:0] setM;
  logic [7:0] clrM;
  logic [7:0] q;
  logic       so;
  logic       conflict;
  logic [3:0] chgCnt;
`ifdef DFFSR_BANK_PARITY_EN
  logic       par;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rstN;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       si;
    logic [7:0] setM;
    logic [7:0] clrM;
    logic [7:0] expQ;
    logic       expSo;
    logic       expConf;
    logic [3:0] expCnt;
  } vec_t;

  vec_t vecs[21];

  dffsr_bank #(
    .WIDTH     (8),
    .RESET_VAL (8'hA5),
    .CNT_W     (4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .en_i       (en),
    .mode_i     (mode),
    .d_i        (d),
    .si_i       (si),
    .set_i      (setM),
    .clr_i      (clrM),
    .q_o        (q),
    .so_o       (so),
    .conflict_o (conflict),
`ifdef DFFSR_BANK_PARITY_EN
    .par_o      (par),
`endif
    .chg_cnt_o  (chgCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic e, logic [2:0] m, logic [7:0] dd,
                              logic s, logic [7:0] st, logic [7:0] cl,
                              logic [7:0] eq, logic eso, logic ec, logic [3:0] ecnt);
    vec_t v;
    v.rstN = r;  v.en = e;  v.mode = m;  v.d = dd;  v.si = s;
    v.setM = st; v.clrM = cl;
    v.expQ = eq; v.expSo = eso; v.expConf = ec; v.expCnt = ecnt;
    return v;
  endfunction

  // Drives one cycle of inputs and returns 1 time unit after the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [2:0] m,
                               input logic [7:0] dd, input logic s,
                               input logic [7:0] st, input logic [7:0] cl);
    rstN = r; en = e; mode = m; d = dd; si = s; setM = st; clrM = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expQ,
                             input logic expSo, input logic expConf,
                             input logic [3:0] expCnt);
    total++;
    if (q !== expQ) begin
      bad++;
      $display("[TB] FAIL %s q: got %h want %h", tag, q, expQ);
    end
    total++;
    if (so !== expSo) begin
      bad++;
      $display("[TB] FAIL %s so: got %b want %b", tag, so, expSo);
    end
    total++;
    if (conflict !== expConf) begin
      bad++;
      $display("[TB] FAIL %s conflict: got %b want %b", tag, conflict, expConf);
    end
    total++;
    if (chgCnt !== expCnt) begin
      bad++;
      $display("[TB] FAIL %s chg_cnt: got %0d want %0d", tag, chgCnt, expCnt);
    end
`ifdef DFFSR_BANK_PARITY_EN
    total++;
    if (par !== ^expQ) begin
      bad++;
      $display("[TB] FAIL %s par: got %b want %b", tag, par, ^expQ);
    end
`endif
  endtask

  initial begin
    logic [7:0] invQ;
    logic [3:0] invCnt;

    rstN = 1'b0; en = 1'b0; mode = 3'd0; d = 8'h00; si = 1'b0;
    setM = 8'h00; clrM = 8'h00;

    //             rst  en  mode  d      si    set    clr     Q      SO    CONF  CNT
    vecs[0]  = mk(1'b0,1'b1,3'd1,8'hFF,1'b0,8'h00,8'h00, 8'hA5,1'b0,1'b0,4'd0);
    vecs[1]  = mk(1'b0,1'b1,3'd1,8'hFF,1'b0,8'h00,8'h00, 8'hA5,1'b0,1'b0,4'd0);
    vecs[2]  = mk(1'b1,1'b1,3'd1,8'h81,1'b0,8'h00,8'h00, 8'h81,1'b0,1'b0,4'd1);
    vecs[3]  = mk(1'b1,1'b1,3'd2,8'h00,1'b0,8'h00,8'h00, 8'h02,1'b1,1'b0,4'd2);
    vecs[4]  = mk(1'b1,1'b1,3'd3,8'h00,1'b1,8'h00,8'h00, 8'h81,1'b0,1'b0,4'd3);
    vecs[5]  = mk(1'b1,1'b1,3'd1,8'h00,1'b0,8'h00,8'h00, 8'h00,1'b0,1'b0,4'd4);
    vecs[6]  = mk(1'b1,1'b0,3'd1,8'hFF,1'b0,8'h0F,8'h03, 8'h0C,1'b0,1'b1,4'd5);
    vecs[7]  = mk(1'b1,1'b0,3'd1,8'hFF,1'b0,8'h00,8'h00, 8'h0C,1'b0,1'b0,4'd5);
    vecs[8]  = mk(1'b1,1'b1,3'd1,8'h80,1'b0,8'h00,8'h00, 8'h80,1'b0,1'b0,4'd6);
    vecs[9]  = mk(1'b1,1'b1,3'd4,8'h00,1'b0,8'h00,8'h00, 8'h01,1'b1,1'b0,4'd7);
    vecs[10] = mk(1'b1,1'b1,3'd6,8'h00,1'b0,8'h00,8'h00, 8'hFE,1'b1,1'b0,4'd8);
    vecs[11] = mk(1'b1,1'b1,3'd7,8'h00,1'b1,8'h00,8'h00, 8'hFE,1'b1,1'b0,4'd8);
    vecs[12] = mk(1'b1,1'b1,3'd7,8'h00,1'b1,8'h00,8'h00, 8'hFE,1'b1,1'b0,4'd8);
    vecs[13] = mk(1'b1,1'b1,3'd7,8'h00,1'b1,8'h00,8'h00, 8'hFE,1'b1,1'b0,4'd8);
    vecs[14] = mk(1'b1,1'b1,3'd1,8'h00,1'b0,8'hFF,8'h00, 8'hFF,1'b1,1'b0,4'd9);
    vecs[15] = mk(1'b1,1'b1,3'd6,8'h00,1'b0,8'h00,8'hFF, 8'h00,1'b1,1'b0,4'd10);
    vecs[16] = mk(1'b1,1'b1,3'd0,8'h00,1'b0,8'hFF,8'h01, 8'hFE,1'b1,1'b1,4'd11);
    vecs[17] = mk(1'b1,1'b1,3'd5,8'h00,1'b1,8'h00,8'h00, 8'h7F,1'b0,1'b0,4'd12);
    vecs[18] = mk(1'b1,1'b1,3'd3,8'h00,1'b1,8'h00,8'h80, 8'h3F,1'b1,1'b0,4'd13);
    vecs[19] = mk(1'b1,1'b0,3'd2,8'h00,1'b1,8'h00,8'h00, 8'h3F,1'b1,1'b0,4'd13);
    vecs[20] = mk(1'b1,1'b1,3'd2,8'h00,1'b1,8'h00,8'h01, 8'h7E,1'b0,1'b0,4'd14);

    @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].en, vecs[i].mode, vecs[i].d,
                    vecs[i].si, vecs[i].setM, vecs[i].clrM);
      checkOutput($sformatf("vec%0d", i), vecs[i].expQ, vecs[i].expSo,
                  vecs[i].expConf, vecs[i].expCnt);
    end

    // Twenty inverts from 8'h7E: counter reaches 15 on the first and stays.
    invQ   = 8'h7E;
    invCnt = 4'd14;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b1, 3'd6, 8'h00, 1'b0, 8'h00, 8'h00);
      invQ = ~invQ;
      if (invCnt != 4'hF) invCnt = invCnt + 4'd1;
      checkOutput($sformatf("sat%0d", k), invQ, 1'b0, 1'b0, invCnt);
    end

    // Reset in the middle of a shift sequence, with conflicting masks present.
    applyStimulus(1'b1, 1'b1, 3'd1, 8'h01, 1'b0, 8'h00, 8'h00);
    checkOutput("mid_load", 8'h01, 1'b0, 1'b0, 4'hF);
    applyStimulus(1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 8'h00, 8'h00);
    checkOutput("mid_shl", 8'h02, 1'b0, 1'b0, 4'hF);
    applyStimulus(1'b0, 1'b1, 3'd2, 8'h00, 1'b1, 8'hFF, 8'hFF);
    checkOutput("mid_rst", 8'hA5, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 8'h00, 8'h00);
    checkOutput("post_rst_shl", 8'h4A, 1'b1, 1'b0, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
